// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory instruction codes, the memory-access FSM
// state type, and small decode helpers used by the memory access unit.
package mips_pkg;

  typedef enum logic [6:0] {
    LB  = 7'd42,
    LBU = 7'd43,
    LH  = 7'd44,
    LHU = 7'd45,
    LUI = 7'd46,
    LW  = 7'd47,
    LWL = 7'd48,
    LWR = 7'd49,
    SB  = 7'd50,
    SH  = 7'd51,
    SW  = 7'd52
  } instcode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_t;

  // Loads that read the bus (LUI is not a memory operation).
  function automatic logic is_load(input logic [6:0] op);
    case (op)
      LB, LBU, LH, LHU, LW, LWL, LWR: is_load = 1'b1;
      default:                        is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    case (op)
      SB, SH, SW: is_store = 1'b1;
      default:    is_store = 1'b0;
    endcase
  endfunction

  // Halfword ops need an even address, word ops and fetches a word-aligned one.
  // LWL/LWR are unaligned by design and never fault.
  function automatic logic is_misaligned(input logic fetch, input logic [6:0] op,
                                         input logic [1:0] lo);
    if (fetch) begin
      is_misaligned = (lo != 2'b00);
    end else begin
      case (op)
        LH, LHU, SH: is_misaligned = lo[0];
        LW, SW:      is_misaligned = (lo != 2'b00);
        default:     is_misaligned = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane logic: byteenable generation, store-data
// replication, and load extension / LWL-LWR merge of a captured bus word.
module mem_lane_steer
  import mips_pkg::*;
(
  input  logic        i_fetch,
  input  logic [6:0]  i_op,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rt_old,
  input  logic [31:0] i_word,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  output logic [31:0] o_load_result
);

  logic [4:0]  w_shr;
  logic [4:0]  w_shl;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;

  assign w_shr  = {i_lo, 3'b000};
  assign w_shl  = {2'd3 - i_lo, 3'b000};
  assign w_byte = i_word[w_shr +: 8];
  assign w_half = i_lo[1] ? i_word[31:16] : i_word[15:0];
  // LWL fills the top k+1 bytes from memory; LWR fills the bottom 4-k bytes.
  assign w_lwl  = (i_word << w_shl) | (i_rt_old & ((32'hFFFF_FFFF >> w_shr) >> 8));
  assign w_lwr  = (i_word >> w_shr) | (i_rt_old & ~(32'hFFFF_FFFF >> w_shr));

  // Decode lanes, steer store data and shape the load result per opcode.
  always_comb begin
    o_byteenable  = 4'b0000;
    o_writedata   = i_store_data;
    o_load_result = 32'h0;
    if (i_fetch) begin
      o_byteenable  = 4'b1111;
      o_load_result = i_word;
    end else begin
      case (i_op)
        LB:  begin o_byteenable = 4'b0001 << i_lo; o_load_result = {{24{w_byte[7]}}, w_byte}; end
        LBU: begin o_byteenable = 4'b0001 << i_lo; o_load_result = {24'h0, w_byte}; end
        LH:  begin o_byteenable = i_lo[1] ? 4'b1100 : 4'b0011; o_load_result = {{16{w_half[15]}}, w_half}; end
        LHU: begin o_byteenable = i_lo[1] ? 4'b1100 : 4'b0011; o_load_result = {16'h0, w_half}; end
        LW:  begin o_byteenable = 4'b1111; o_load_result = i_word; end
        LWL: begin o_byteenable = 4'b1111 >> (2'd3 - i_lo); o_load_result = w_lwl; end
        LWR: begin o_byteenable = 4'b1111 << i_lo; o_load_result = w_lwr; end
        SB:  begin o_byteenable = 4'b0001 << i_lo; o_writedata = {4{i_store_data[7:0]}}; end
        SH:  begin o_byteenable = i_lo[1] ? 4'b1100 : 4'b0011; o_writedata = {2{i_store_data[15:0]}}; end
        SW:  o_byteenable = 4'b1111;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential memory access unit: one fetch or load/store at a time onto an
// Avalon-MM style port with registered strobes, fault and timeout reporting.
// Optional bus timeout is compiled in with `define MEM_ACCESS_TIMEOUT_EN.
// Handshake: a request is taken on a clock edge where req_valid and req_ready
// are both high; req_ready is high only in IDLE, so req_valid while busy is
// ignored. done pulses for one cycle with fault/timeout/load_data valid.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fetch,
  input  logic [6:0]        instcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       rt_old,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              fault,
  output logic              timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [1:0]        o_dbg_state
);

  mau_state_t        r_state, w_next;
  logic              r_fetch;
  logic [6:0]        r_op;
  logic [1:0]        r_lo;
  logic [31:0]       r_rt_old;
  logic [ADDR_W-1:0] r_avm_address;
  logic              r_avm_read, r_avm_write;
  logic [3:0]        r_avm_be;
  logic [31:0]       r_avm_wdata;
  logic [31:0]       r_load_data;
  logic              r_fault, r_timeout;

  logic              w_idle, w_accept, w_is_mem, w_misalign, w_go_bus;
  logic              w_bus_done, w_abort;
  logic              w_sel_fetch;
  logic [6:0]        w_sel_op;
  logic [1:0]        w_sel_lo;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_load_result;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = req_valid && w_idle;
  assign w_is_mem   = req_fetch || is_load(instcode) || is_store(instcode);
  assign w_misalign = is_misaligned(req_fetch, instcode, addr[1:0]);
  assign w_go_bus   = w_is_mem && !w_misalign;
  assign w_bus_done = (r_state == ST_ACCESS) && !avm_waitrequest;

  // Lane logic sees the live request while idle and the latched one afterwards.
  assign w_sel_fetch = w_idle ? req_fetch  : r_fetch;
  assign w_sel_op    = w_idle ? instcode   : r_op;
  assign w_sel_lo    = w_idle ? addr[1:0]  : r_lo;

  mem_lane_steer u_steer (
    .i_fetch       (w_sel_fetch),
    .i_op          (w_sel_op),
    .i_lo          (w_sel_lo),
    .i_store_data  (store_data),
    .i_rt_old      (r_rt_old),
    .i_word        (avm_readdata),
    .o_byteenable  (w_be),
    .o_writedata   (w_wdata),
    .o_load_result (w_load_result)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Count stalled cycles of the current access; restart on every accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_wait_cnt <= '0;
    else if (w_accept)                             r_wait_cnt <= '0;
    else if (r_state == ST_ACCESS && avm_waitrequest) r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  assign w_abort = (r_state == ST_ACCESS) && avm_waitrequest &&
                   (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_abort = 1'b0;
  // The limit only matters when the timeout is compiled in.
  if (TIMEOUT_CYCLES < 1) begin : g_unused_limit
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_go_bus ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (w_bus_done || w_abort) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Moore outputs; fault/timeout are only meaningful alongside done.
  always_comb begin
    req_ready   = (r_state == ST_IDLE);
    done        = (r_state == ST_RESP);
    fault       = done && r_fault;
    timeout     = done && r_timeout;
    o_dbg_state = r_state;
  end

  // Request latch, bus registers and load result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch       <= 1'b0;
      r_op          <= 7'd0;
      r_lo          <= 2'b00;
      r_rt_old      <= 32'h0;
      r_avm_address <= '0;
      r_avm_read    <= 1'b0;
      r_avm_write   <= 1'b0;
      r_avm_be      <= 4'b0000;
      r_avm_wdata   <= 32'h0;
      r_load_data   <= 32'h0;
      r_fault       <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_fetch   <= req_fetch;
          r_op      <= instcode;
          r_lo      <= addr[1:0];
          r_rt_old  <= rt_old;
          r_fault   <= w_misalign;
          r_timeout <= 1'b0;
          if (w_go_bus) begin
            r_avm_address <= {addr[ADDR_W-1:2], 2'b00};
            r_avm_read    <= req_fetch || is_load(instcode);
            r_avm_write   <= !req_fetch && is_store(instcode);
            r_avm_be      <= w_be;
            r_avm_wdata   <= w_wdata;
          end else if (!w_is_mem) begin
            r_load_data <= 32'h0;
          end
        end
        ST_ACCESS: begin
          if (w_bus_done) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            if (r_avm_read) r_load_data <= w_load_result;
          end else if (w_abort) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_timeout   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign avm_address    = r_avm_address;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_byteenable = r_avm_be;
  assign avm_writedata  = r_avm_wdata;
  assign load_data      = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized requests
// against a byte-level reference model of the load/store rules.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_fetch;
  logic [6:0]  instcode;
  logic [31:0] addr, store_data, rt_old;
  logic        done, fault, timeout;
  logic [31:0] load_data;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;
  logic [1:0]  o_dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ld = 32'h0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fetch(req_fetch),
    .instcode(instcode), .addr(addr), .store_data(store_data), .rt_old(rt_old),
    .done(done), .load_data(load_data), .fault(fault), .timeout(timeout),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input logic [6:0] op);
    return (op >= 7'd42 && op <= 7'd45) || (op >= 7'd47 && op <= 7'd49);
  endfunction

  function automatic bit m_is_store(input logic [6:0] op);
    return op >= 7'd50 && op <= 7'd52;
  endfunction

  // Alignment unit in bytes (LWL/LWR behave like byte accesses).
  function automatic int m_size(input logic f, input logic [6:0] op);
    if (f) return 4;
    case (op)
      7'd44, 7'd45, 7'd51: return 2;
      7'd47, 7'd52:        return 4;
      default:             return 1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic f, input logic [6:0] op, input int k);
    logic [3:0] be;
    be = 4'b0;
    for (int l = 0; l < 4; l++) begin
      if (f || op == 7'd47 || op == 7'd52)              be[l] = 1'b1;
      else if (op == 7'd42 || op == 7'd43 || op == 7'd50) be[l] = (l == k);
      else if (op == 7'd44 || op == 7'd45 || op == 7'd51) be[l] = ((l / 2) == (k / 2));
      else if (op == 7'd48)                              be[l] = (l <= k);
      else if (op == 7'd49)                              be[l] = (l >= k);
    end
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [6:0] op, input logic [31:0] sd);
    if (op == 7'd50) return {24'h0, sd[7:0]} * 32'h0101_0101;
    if (op == 7'd51) return {16'h0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic f, input logic [6:0] op, input int k,
                                         input logic [31:0] rt, input logic [31:0] w);
    logic [7:0]  wb[4];
    logic [7:0]  rb[4];
    logic [7:0]  ob[4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) begin
      wb[i] = w[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    h = {wb[(k/2)*2 + 1], wb[(k/2)*2]};
    if (f || op == 7'd47) return w;
    case (op)
      7'd42: return 32'($signed(wb[k]));
      7'd43: return {24'h0, wb[k]};
      7'd44: return 32'($signed(h));
      7'd45: return {16'h0, h};
      7'd48: begin
        for (int i = 0; i < 4; i++) ob[i] = (i >= 3 - k) ? wb[i - (3 - k)] : rb[i];
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      7'd49: begin
        for (int i = 0; i < 4; i++) ob[i] = (i <= 3 - k) ? wb[i + k] : rb[i];
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic drive_junk();
    req_fetch  = 1'($urandom_range(0, 1));
    instcode   = 7'($urandom_range(40, 54));
    addr       = $urandom;
    store_data = $urandom;
    rt_old     = $urandom;
  endtask

  // One request from accept to the cycle after done; 'waits' stall cycles.
  task automatic run_req(input logic f, input logic [6:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rt, input logic [31:0] w,
                         input int waits, input bit junk);
    bit is_ld, is_st, mis;
    int k;
    logic [31:0] e_ld;
    k     = int'(a[1:0]);
    is_ld = f || m_is_load(op);
    is_st = !f && m_is_store(op);
    mis   = (is_ld || is_st) && (k % m_size(f, op) != 0);
    if (!(is_ld || is_st))  e_ld = 32'h0;
    else if (mis || is_st)  e_ld = exp_ld;
    else                    e_ld = m_load(f, op, k, rt, w);
    exp_q.push_back(e_ld);
    exp_ld = e_ld;

    @(negedge clk);
    req_valid = 1'b1; req_fetch = f; instcode = op; addr = a;
    store_data = sd; rt_old = rt;
    avm_waitrequest = 1'b1; avm_readdata = $urandom;
    check_eq("ready_idle", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    if (!(is_ld || is_st) || mis) begin
      req_valid = 1'b0;
      check_eq("done_fast", {31'b0, done}, 32'd1);
      check_eq("fault", {31'b0, fault}, {31'b0, mis});
      check_eq("no_strobe", {30'b0, avm_read, avm_write}, 32'd0);
      check_eq("load_data_fast", load_data, exp_q.pop_front());
    end else begin
      for (int c = 1; c <= waits + 1; c++) begin
        check_eq("strobes", {30'b0, avm_read, avm_write}, {30'b0, 1'(is_ld), 1'(is_st)});
        check_eq("byteenable", {28'b0, avm_byteenable}, {28'b0, m_be(f, op, k)});
        check_eq("address", avm_address, {a[31:2], 2'b00});
        if (is_st) check_eq("writedata", avm_writedata, m_wdata(op, sd));
        check_eq("busy_not_ready", {31'b0, req_ready}, 32'd0);
        check_eq("no_early_done", {31'b0, done}, 32'd0);
        avm_waitrequest = (c <= waits);
        avm_readdata    = (c <= waits) ? $urandom : w;
        if (junk) drive_junk();
        @(negedge clk);
      end
      req_valid = 1'b0;
      check_eq("done", {31'b0, done}, 32'd1);
      check_eq("fault_clear", {31'b0, fault}, 32'd0);
      check_eq("strobes_drop", {30'b0, avm_read, avm_write}, 32'd0);
      check_eq("load_data", load_data, exp_q.pop_front());
    end
    check_eq("timeout_clear", {31'b0, timeout}, 32'd0);
    avm_waitrequest = 1'b1;
    @(negedge clk);
    check_eq("done_one_cycle", {31'b0, done}, 32'd0);
    check_eq("ready_again", {31'b0, req_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b1; req_valid = 1'b0; req_fetch = 1'b0; instcode = 7'd0;
    addr = 32'h0; store_data = 32'h0; rt_old = 32'h0;
    avm_readdata = 32'h0; avm_waitrequest = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_flags", {30'b0, fault, timeout}, 32'd0);
    check_eq("rst_strobes", {30'b0, avm_read, avm_write}, 32'd0);
    check_eq("rst_be", {28'b0, avm_byteenable}, 32'd0);
    check_eq("rst_address", avm_address, 32'd0);
    check_eq("rst_wdata", avm_writedata, 32'd0);
    check_eq("rst_load_data", load_data, 32'd0);
    check_eq("rst_state", {30'b0, o_dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases.
    run_req(1'b1, 7'd0,  32'h0000_1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    check_eq("fetch_value", load_data, 32'hDEAD_BEEF);
    run_req(1'b0, 7'd42, 32'h0000_0103, 32'h0, 32'h0, 32'h8011_2233, 3, 1'b0);
    check_eq("lb_value", load_data, 32'hFFFF_FF80);
    run_req(1'b0, 7'd43, 32'h0000_0103, 32'h0, 32'h0, 32'h8011_2233, 0, 1'b0);
    check_eq("lbu_value", load_data, 32'h0000_0080);
    run_req(1'b0, 7'd51, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 32'h0, 1, 1'b0);
    check_eq("sh_keeps_load_data", load_data, 32'h0000_0080);
    run_req(1'b0, 7'd48, 32'h0000_0101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 1'b0);
    check_eq("lwl_value", load_data, 32'h2211_CCDD);
    run_req(1'b0, 7'd49, 32'h0000_0101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 1'b0);
    check_eq("lwr_value", load_data, 32'hAA44_3322);
    run_req(1'b0, 7'd47, 32'h0000_0102, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    run_req(1'b0, 7'd47, 32'h0000_0300, 32'h0, 32'h0, 32'h5566_7788, 2, 1'b1);
    run_req(1'b0, 7'd46, 32'h0000_0300, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    check_eq("lui_zero", load_data, 32'h0);

    // Randomized requests.
    for (int n = 0; n < 200; n++) begin
      run_req(1'($urandom_range(0, 3) == 0), 7'($urandom_range(40, 54)), $urandom,
              $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Stuck waitrequest: strobe for TO_CYC cycles, then abort.
    @(negedge clk);
    req_valid = 1'b1; req_fetch = 1'b0; instcode = 7'd47; addr = 32'h40;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= TO_CYC; c++) begin
      check_eq("to_strobe", {31'b0, avm_read}, 32'd1);
      @(negedge clk);
    end
    check_eq("to_done", {31'b0, done}, 32'd1);
    check_eq("to_flag", {31'b0, timeout}, 32'd1);
    check_eq("to_strobe_drop", {31'b0, avm_read}, 32'd0);
    check_eq("to_load_data", load_data, exp_ld);
    @(negedge clk);
`endif

    // Reset during ACCESS drops strobes at once and produces no done.
    @(negedge clk);
    req_valid = 1'b1; req_fetch = 1'b0; instcode = 7'd52; addr = 32'h80;
    store_data = 32'hCAFE_F00D; avm_waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("mid_write", {31'b0, avm_write}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_strobes", {30'b0, avm_read, avm_write}, 32'd0);
    check_eq("mid_rst_done", {31'b0, done}, 32'd0);
    check_eq("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    exp_ld = 32'h0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", {31'b0, done}, 32'd0);
    run_req(1'b0, 7'd44, 32'h0000_0502, 32'h0, 32'h0, 32'h8001_7FFF, 1, 1'b0);
    check_eq("lh_value", load_data, 32'hFFFF_8001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
